mem_req_queue: RTL and testbench
================================

// Module: mem_req_queue
// PURPOSE
//  Parametrised EXE-stage load/store issue unit with multiple outstanding requests.
//  - Accepts memory ops from EXE and performs alignment checking and store lane/strobe generation.
//  - Issues ops on the req/addr_ok/data_ok SRAM-like bus and tracks up to DEPTH in-flight ops in order.
//  - Returns load data, byte-aligned, to MEM.
//  - Flush (WB exception/ertn) drops queued ops; responses for ops already on the bus are silently discarded.
// PARAMETERS
//  DATA_W   32  bus data width, 32 or 64
//  ADDR_W   32  address width
//  DEPTH    4   max ops held (issued + completed-not-consumed), power of 2, >=2
//  TAG_W    5   opaque tag width (dest reg), returned with result
// PORTS
//  clk           in   1         clock
//  resetn        in   1         synchronous reset, active low
//  in_valid      in   1         EXE offers a memory op
//  in_ready      out  1         op accepted when in_valid&in_ready
//  in_wr         in   1         1=store, 0=load
//  in_size       in   2         0=B 1=H 2=W 3=D (D legal only if DATA_W=64)
//  in_addr       in   ADDR_W    byte address
//  in_wdata      in   DATA_W    store data, low-aligned
//  in_tag        in   TAG_W     tag
//  in_ale        out  1         comb: in_valid & misaligned/illegal size
//  flush         in   1         drop all un-consumed ops this cycle
//  req           out  1         bus request
//  req_wr        out  1         bus write
//  req_size      out  2         bus size
//  req_addr      out  ADDR_W    bus address
//  req_wstrb     out  DATA_W/8  byte strobes, 0 for loads
//  req_wdata     out  DATA_W    lane-replicated store data
//  req_addr_ok   in   1         slave accepted request
//  resp_data_ok  in   1         one in-order response
//  resp_rdata    in   DATA_W    load data, bus-lane aligned
//  out_valid     out  1         head op complete
//  out_ready     in   1         MEM consumes head
//  out_tag       out  TAG_W     head tag
//  out_wr        out  1         head was store
//  out_ale       out  1         head faulted (not issued)
//  out_rdata     out  DATA_W    load data shifted right by addr byte offset
// BEHAVIOUR
//  Reset: req=0, out_valid=0, in_ready=0 during reset, queue empty, discard cnt=0; all data outputs 0.
//  OFF = log2(DATA_W/8). ALE if size>OFF or addr[size-1:0]!=0.
//  Accept: in_ready = count<DEPTH & ~req_hold.
//  - Accepted op gets a FIFO entry {tag,wr,ale,addr[OFF-1:0],size,done,rdata}.
//  - Non-ALE op loads the request register; req=1 next cycle (latency 1).
//  - ALE op is never issued; it is marked done immediately.
//  req_hold = req & ~req_addr_ok.
//  - req fields stay stable until addr_ok; req is never withdrawn, flush included.
//  - req drops the cycle after addr_ok unless a new op is accepted in the same cycle.
//  Store data: B -> 8b replicated, H -> 16b replicated, W -> 32b replicated (on 64b bus).
//  - wstrb = ((1<<(1<<size))-1) << addr[OFF-1:0].
//  Responses: each data_ok (when discard=0) completes the oldest issued, not-done entry and writes rdata.
//  - Stores also complete on data_ok.
//  - A data_ok with no matching entry is an illegal bus event; the bench asserts on it.
//  Output: out_valid = head.done; pop on out_valid&out_ready; out_* from head entry, registered.
//  - Result held stable while out_ready=0.
//  Full/empty:
//  - count==DEPTH -> in_ready=0.
//  - Push and pop in the same cycle keep count; allowed when full (pop frees slot, in_ready stays 0 that cycle).
//  Flush (priority over accept/pop that cycle):
//  - discard += entries issued-not-done, plus 1 if req_hold.
//  - Queue emptied; out_valid=0 next cycle.
//  - While discard>0, each data_ok decrements discard and is dropped.
//  - New ops are accepted next cycle normally; their responses follow the discarded ones.
//  - Simultaneous flush & data_ok: that response counts against the pre-flush entry, i.e. is not added to discard.
//  Reset mid-operation: all state cleared; the bus slave is reset in the same domain.
// TESTING
//  1) Load W @0x1004 (DATA_W=32) -> req=1 next cycle, size=2, wstrb=0; data_ok rdata=0xA5A5_1234 -> out_valid, out_rdata=0xA5A5_1234, out_tag echoed.
//  2) Store B 0x7E @0x1003 -> wdata=0x7E7E7E7E, wstrb=4'b1000. Store H @0x1001 -> in_ale=1, no req, out_ale=1 in order behind earlier ops.
//  3) DEPTH=4, addr_ok every cycle, no data_ok -> 4 accepts then in_ready=0; 4 data_ok returned -> in order, count back to 0.
//  4) 3 issued, 1 req_hold, flush -> discard=4; next 4 data_ok produce no out_valid; the op accepted after flush gets the 5th response.
//  5) Full queue, out_ready=0 for 10 cycles -> head outputs stable; out_ready=1 -> pop, in_ready=1 next cycle.
//  6) DATA_W=64: store D @0x8 -> wstrb=8'hFF; load B @0xD data 0x1122334455667788 -> out_rdata[7:0]=0x33.

Source files
------------

// File: rtl/mem_req_queue.sv
// EXE-stage load/store issue unit: alignment check, store lane/strobe generation and
// in-order tracking of up to DEPTH ops on an SRAM-like req/addr_ok/data_ok bus.
module mem_req_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wr,
    input  logic [1:0]            in_size,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  in_ale,
    input  logic                  flush,
    output logic                  req,
    output logic                  req_wr,
    output logic [1:0]            req_size,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [DATA_W/8-1:0]   req_wstrb,
    output logic [DATA_W-1:0]     req_wdata,
    input  logic                  req_addr_ok,
    input  logic                  resp_data_ok,
    input  logic [DATA_W-1:0]     resp_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_wr,
    output logic                  out_ale,
    output logic [DATA_W-1:0]     out_rdata
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFF    = $clog2(NB);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DISC_W = PTR_W + 4;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              wr;
        logic              ale;
        logic [OFF-1:0]    off;
        logic [DATA_W-1:0] rdata;
    } ent_t;

    ent_t              ent_q [DEPTH];
    ent_t              ent_d [DEPTH];
    logic [DEPTH-1:0]  done_q, done_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DISC_W-1:0] disc_q, disc_d;

    logic              req_q, req_d;
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [NB-1:0]     req_wstrb_q, req_wstrb_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_wr_q, out_wr_d;
    logic              out_ale_q, out_ale_d;
    logic [DATA_W-1:0] out_rdata_q, out_rdata_d;

    logic [OFF-1:0]    in_off;
    logic [OFF-1:0]    size_mask;
    logic              ale_op;
    logic [NB-1:0]     strb_base;
    logic [NB-1:0]     wstrb_op;
    logic [DATA_W-1:0] wdata_rep;
    logic              req_hold;
    logic              accept;
    logic              pop;

    logic              rsp_hit;
    logic [PTR_W-1:0]  rsp_idx;
    logic [PTR_W-1:0]  scan_idx;
    logic [CNT_W-1:0]  notdone_cnt;
    logic              rsp_fire;

    // Alignment: size wider than the bus or low address bits not size-aligned
    assign in_off    = in_addr[OFF-1:0];
    assign size_mask = OFF'((32'd1 << in_size) - 32'd1);
    assign ale_op    = (32'(in_size) > OFF) || ((in_off & size_mask) != '0);
    assign in_ale    = in_valid & ale_op;

    assign strb_base = NB'((32'd1 << (32'd1 << in_size)) - 32'd1);
    assign wstrb_op  = in_wr ? NB'(strb_base << in_off) : '0;

    always_comb begin
        wdata_rep = in_wdata;
        unique case (in_size)
            2'd0:    wdata_rep = {NB{in_wdata[7:0]}};
            2'd1:    wdata_rep = {(NB/2){in_wdata[15:0]}};
            2'd2:    wdata_rep = {(NB/4){in_wdata[31:0]}};
            default: wdata_rep = in_wdata;
        endcase
    end

    assign req_hold = req_q & ~req_addr_ok;
    assign in_ready = resetn & (count_q < CNT_W'(DEPTH)) & ~req_hold;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = out_valid_q & out_ready & ~flush;

    // Oldest not-done entry receives the next response; not-done count feeds discard on flush
    always_comb begin
        rsp_hit     = 1'b0;
        rsp_idx     = '0;
        scan_idx    = '0;
        notdone_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && !done_q[scan_idx]) begin
                notdone_cnt = notdone_cnt + CNT_W'(1);
                if (!rsp_hit) begin
                    rsp_hit = 1'b1;
                    rsp_idx = scan_idx;
                end
            end
        end
    end

    assign rsp_fire = resp_data_ok & (disc_q == '0) & rsp_hit;

    always_comb begin
        ent_d       = ent_q;
        done_d      = done_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        disc_d      = disc_q;
        req_d       = req_q;
        req_wr_d    = req_wr_q;
        req_size_d  = req_size_q;
        req_addr_d  = req_addr_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;

        if (rsp_fire) begin
            done_d[rsp_idx] = 1'b1;
            if (!ent_q[rsp_idx].wr) begin
                ent_d[rsp_idx].rdata = resp_rdata;
            end
        end

        if (req_q && req_addr_ok) begin
            req_d = 1'b0;
        end

        if (flush) begin
            // A response landing in the flush cycle already retired one pending op
            disc_d  = disc_q + DISC_W'(notdone_cnt) - DISC_W'(resp_data_ok);
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            done_d  = '0;
        end else begin
            if (resp_data_ok && (disc_q != '0)) begin
                disc_d = disc_q - DISC_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (accept) begin
                ent_d[tail_q].tag   = in_tag;
                ent_d[tail_q].wr    = in_wr;
                ent_d[tail_q].ale   = ale_op;
                ent_d[tail_q].off   = in_off;
                ent_d[tail_q].rdata = '0;
                done_d[tail_q]      = ale_op;
                tail_d              = tail_q + PTR_W'(1);
                if (!ale_op) begin
                    req_d       = 1'b1;
                    req_wr_d    = in_wr;
                    req_size_d  = in_size;
                    req_addr_d  = in_addr;
                    req_wstrb_d = wstrb_op;
                    req_wdata_d = wdata_rep;
                end
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // Output register mirrors the head entry of the next state
    always_comb begin
        out_valid_d = (count_d != '0) && done_d[head_d];
        out_tag_d   = ent_d[head_d].tag;
        out_wr_d    = ent_d[head_d].wr;
        out_ale_d   = ent_d[head_d].ale;
        out_rdata_d = ent_d[head_d].rdata >> {ent_d[head_d].off, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            disc_q      <= '0;
            req_q       <= 1'b0;
            req_wr_q    <= 1'b0;
            req_size_q  <= '0;
            req_addr_q  <= '0;
            req_wstrb_q <= '0;
            req_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_wr_q    <= 1'b0;
            out_ale_q   <= 1'b0;
            out_rdata_q <= '0;
        end else begin
            ent_q       <= ent_d;
            done_q      <= done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            disc_q      <= disc_d;
            req_q       <= req_d;
            req_wr_q    <= req_wr_d;
            req_size_q  <= req_size_d;
            req_addr_q  <= req_addr_d;
            req_wstrb_q <= req_wstrb_d;
            req_wdata_q <= req_wdata_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_wr_q    <= out_wr_d;
            out_ale_q   <= out_ale_d;
            out_rdata_q <= out_rdata_d;
        end
    end

    assign req       = req_q;
    assign req_wr    = req_wr_q;
    assign req_size  = req_size_q;
    assign req_addr  = req_addr_q;
    assign req_wstrb = req_wstrb_q;
    assign req_wdata = req_wdata_q;
    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_wr    = out_wr_q;
    assign out_ale   = out_ale_q;
    assign out_rdata = out_rdata_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue (64-bit bus): directed scenarios plus random traffic,
// checked every cycle against a queue-level behavioural model and a bus slave model.
module tb_mem_req_queue;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 5;
    localparam int unsigned NB    = DW / 8;
    localparam int unsigned OFFB  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          d_resetn = 1'b0;
    logic          d_in_valid = 1'b0, d_wr = 1'b0, d_flush = 1'b0;
    logic [1:0]    d_size = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata = '0;
    logic [TW-1:0] d_tag = '0;
    logic          d_addr_ok = 1'b0, d_data_ok = 1'b0, d_out_ready = 1'b0;

    logic          in_ready, in_ale, req, req_wr, out_valid, out_wr, out_ale;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [NB-1:0] req_wstrb;
    logic [DW-1:0] req_wdata, out_rdata;
    logic [TW-1:0] out_tag;

    mem_req_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .resetn(d_resetn),
        .in_valid(d_in_valid), .in_ready(in_ready), .in_wr(d_wr), .in_size(d_size),
        .in_addr(d_addr), .in_wdata(d_wdata), .in_tag(d_tag), .in_ale(in_ale),
        .flush(d_flush),
        .req(req), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .req_addr_ok(d_addr_ok), .resp_data_ok(d_data_ok), .resp_rdata(d_rdata),
        .out_valid(out_valid), .out_ready(d_out_ready), .out_tag(out_tag),
        .out_wr(out_wr), .out_ale(out_ale), .out_rdata(out_rdata)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic          wr;
        logic          ale;
        logic [AW-1:0] addr;
        logic          done;
        logic [DW-1:0] rdata;
    } ment_t;

    ment_t         mq[$];
    logic          m_req = 1'b0, m_req_wr = 1'b0;
    logic [1:0]    m_req_size = '0;
    logic [AW-1:0] m_req_addr = '0;
    logic [NB-1:0] m_req_wstrb = '0;
    logic [DW-1:0] m_req_wdata = '0;
    int            discard = 0;
    int            bus_pend = 0;
    int            n_checks = 0;
    int            n_err = 0;

    function automatic logic f_ale(input logic [1:0] size, input logic [AW-1:0] addr);
        return (int'(size) > OFFB) || ((addr % (32'd1 << size)) != 32'd0);
    endfunction

    function automatic logic [NB-1:0] f_strb(input logic [1:0] size, input logic [AW-1:0] addr);
        logic [NB-1:0] s = '0;
        int unsigned off = addr % NB;
        for (int unsigned b = 0; b < NB; b++)
            if (b >= off && b < off + (32'd1 << size)) s[b] = 1'b1;
        return s;
    endfunction

    function automatic logic [DW-1:0] f_wdata(input logic [1:0] size, input logic [DW-1:0] d);
        logic [DW-1:0] w = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            int unsigned src = b % (32'd1 << size);
            w = w | (DW'(8'(d >> (8 * src))) << (8 * b));
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] f_rd(input ment_t e);
        if (e.wr || e.ale) return '0;
        return e.rdata >> (8 * (e.addr % NB));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return d_resetn && (mq.size() < DEPTH) && !(m_req && !d_addr_ok);
    endfunction

    function automatic logic exp_ovalid();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    task automatic compare_all();
        chk("in_ready", in_ready, exp_ready());
        chk("in_ale", in_ale, d_in_valid && f_ale(d_size, d_addr));
        chk("req", req, m_req);
        if (m_req) begin
            chk("req_wr", req_wr, m_req_wr);
            chk("req_size", req_size, m_req_size);
            chk("req_addr", req_addr, m_req_addr);
            chk("req_wstrb", req_wstrb, m_req_wstrb);
            if (m_req_wr) chk("req_wdata", req_wdata, m_req_wdata);
        end
        chk("out_valid", out_valid, exp_ovalid());
        if (exp_ovalid()) begin
            chk("out_tag", out_tag, mq[0].tag);
            chk("out_wr", out_wr, mq[0].wr);
            chk("out_ale", out_ale, mq[0].ale);
            chk("out_rdata", out_rdata, f_rd(mq[0]));
        end
    endtask

    task automatic model_update();
        logic acc, pp, found;
        int nd;
        if (!d_resetn) begin
            mq.delete();
            m_req = 1'b0;
            discard = 0;
            bus_pend = 0;
            return;
        end
        acc = d_in_valid && exp_ready() && !d_flush;
        pp  = exp_ovalid() && d_out_ready && !d_flush;
        if (d_data_ok) begin
            bus_pend--;
            if (discard > 0) begin
                discard--;
            end else begin
                found = 1'b0;
                foreach (mq[i]) begin
                    if (!found && !mq[i].done) begin
                        mq[i].done  = 1'b1;
                        mq[i].rdata = d_rdata;
                        found = 1'b1;
                    end
                end
                chk("orphan_resp", found, 1'b1);
            end
        end
        if (m_req && d_addr_ok) begin
            bus_pend++;
            m_req = 1'b0;
        end
        if (d_flush) begin
            nd = 0;
            foreach (mq[i]) if (!mq[i].done) nd++;
            discard += nd;
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                ment_t e;
                e.tag = d_tag; e.wr = d_wr; e.addr = d_addr;
                e.ale = f_ale(d_size, d_addr);
                e.done = e.ale; e.rdata = '0;
                mq.push_back(e);
                if (!e.ale) begin
                    m_req       = 1'b1;
                    m_req_wr    = d_wr;
                    m_req_size  = d_size;
                    m_req_addr  = d_addr;
                    m_req_wstrb = d_wr ? f_strb(d_size, d_addr) : '0;
                    m_req_wdata = f_wdata(d_size, d_wdata);
                end
            end
        end
    endtask

    task automatic clear();
        d_resetn = 1'b1; d_in_valid = 1'b0; d_wr = 1'b0; d_size = '0; d_addr = '0;
        d_wdata = '0; d_tag = '0; d_flush = 1'b0; d_addr_ok = 1'b0; d_data_ok = 1'b0;
        d_rdata = '0; d_out_ready = 1'b1;
    endtask

    task automatic op(input logic wr, input logic [1:0] size, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [TW-1:0] tag);
        d_in_valid = 1'b1; d_wr = wr; d_size = size; d_addr = addr; d_wdata = wdata; d_tag = tag;
    endtask

    task automatic settle();
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        @(negedge clk);
        clear(); d_resetn = 1'b0; d_out_ready = 1'b0;
        settle();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_req", req, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_addr", req_addr, 64'h0);
        chk("rst_req_wdata", req_wdata, 64'h0);
        chk("rst_out_tag", out_tag, 64'h0);
        chk("rst_out_rdata", out_rdata, 64'h0);
        advance();
        clear(); d_resetn = 1'b0; cycle();

        // Load W @0x1004, response lands in upper lane
        clear(); op(1'b0, 2'd2, 32'h1004, '0, 5'd5); settle();
        chk("t1_in_ready", in_ready, 1'b1); advance();
        clear(); d_addr_ok = 1'b1; settle();
        chk("t1_req", req, 1'b1); chk("t1_req_size", req_size, 2);
        chk("t1_req_wstrb", req_wstrb, 0); chk("t1_req_addr", req_addr, 32'h1004); advance();
        clear(); d_data_ok = 1'b1; d_rdata = 64'hA5A5_1234_0000_0000; cycle();
        clear(); settle();
        chk("t1_out_valid", out_valid, 1'b1); chk("t1_out_rdata", out_rdata, 64'hA5A5_1234);
        chk("t1_out_tag", out_tag, 5); advance();

        // Store B replication/strobe, then misaligned store H behind it
        clear(); op(1'b1, 2'd0, 32'h1003, 64'h7E, 5'd6); cycle();
        clear(); op(1'b1, 2'd1, 32'h1001, 64'h55, 5'd7); d_addr_ok = 1'b1; settle();
        chk("t2_in_ale", in_ale, 1'b1); chk("t2_req_wdata", req_wdata, 64'h7E7E_7E7E_7E7E_7E7E);
        chk("t2_req_wstrb", req_wstrb, 8'h08); advance();
        clear(); settle(); chk("t2_no_req", req, 1'b0); advance();
        clear(); d_data_ok = 1'b1; cycle();
        clear(); settle(); chk("t2_head6", out_tag, 6); chk("t2_wr6", out_wr, 1'b1); advance();
        clear(); settle(); chk("t2_head7", out_tag, 7); chk("t2_ale7", out_ale, 1'b1); advance();

        // 64-bit: store D full strobe, load B @0xD
        clear(); op(1'b1, 2'd3, 32'h8, 64'h0102_0304_0506_0708, 5'd8); cycle();
        clear(); op(1'b0, 2'd0, 32'hD, '0, 5'd11); d_addr_ok = 1'b1; settle();
        chk("t6_wstrb_d", req_wstrb, 8'hFF); advance();
        clear(); d_addr_ok = 1'b1; settle(); chk("t6_ld_addr", req_addr, 32'hD); advance();
        clear(); d_data_ok = 1'b1; cycle();
        clear(); d_data_ok = 1'b1; d_rdata = 64'h1122_3344_5566_7788; cycle();
        clear(); settle(); chk("t6_tag", out_tag, 11); chk("t6_rdata", out_rdata, 64'h11_2233); advance();

        // Fill to DEPTH, hold head with out_ready low, then pop
        for (int i = 0; i < 4; i++) begin
            clear(); op(1'b0, 2'd2, 32'h100 + 32'(4 * i), '0, 5'(16 + i));
            d_addr_ok = 1'b1; d_out_ready = 1'b0; cycle();
        end
        clear(); op(1'b0, 2'd2, 32'h200, '0, 5'd31); d_addr_ok = 1'b1; d_out_ready = 1'b0; settle();
        chk("t3_full", in_ready, 1'b0); advance();
        for (int i = 0; i < 4; i++) begin
            clear(); d_out_ready = 1'b0; d_data_ok = 1'b1; d_rdata = {$urandom, $urandom}; cycle();
        end
        for (int i = 0; i < 10; i++) begin
            clear(); d_out_ready = 1'b0; settle(); chk("t5_hold_tag", out_tag, 16); advance();
        end
        clear(); cycle();
        clear(); d_out_ready = 1'b0; settle(); chk("t5_ready_after_pop", in_ready, 1'b1); advance();
        for (int i = 0; i < 4; i++) begin clear(); cycle(); end

        // Flush with 3 issued + 1 held: 4 responses discarded, 5th goes to new op
        clear(); op(1'b0, 2'd2, 32'h20, '0, 5'd1); cycle();
        for (int i = 0; i < 3; i++) begin
            clear(); op(1'b0, 2'd2, 32'h24 + 32'(4 * i), '0, 5'(2 + i)); d_addr_ok = 1'b1; cycle();
        end
        clear(); d_flush = 1'b1; cycle();
        chk("t4_model_discard", discard, 4);
        clear(); op(1'b0, 2'd2, 32'h30, '0, 5'd9); d_addr_ok = 1'b1; cycle();
        clear(); d_addr_ok = 1'b1; cycle();
        for (int i = 0; i < 5; i++) begin
            clear(); d_data_ok = 1'b1; d_rdata = 64'(i + 1); settle();
            chk("t4_no_out", out_valid, 1'b0); advance();
        end
        clear(); settle(); chk("t4_new_valid", out_valid, 1'b1); chk("t4_new_tag", out_tag, 9); advance();

        // Random traffic with flushes and a mid-run reset
        for (int c = 0; c < 3000; c++) begin
            clear();
            if (c >= 1500 && c < 1503) d_resetn = 1'b0;
            if ($urandom_range(99) < 60) begin
                logic [1:0] sz;
                logic [AW-1:0] a;
                sz = 2'($urandom_range(3));
                a = $urandom;
                if ($urandom_range(1) == 0) a = a & ~((32'd1 << sz) - 32'd1);
                op(1'($urandom_range(1)), sz, a, {$urandom, $urandom}, 5'($urandom_range(31)));
            end
            d_flush     = ($urandom_range(99) < 4);
            d_addr_ok   = ($urandom_range(99) < 60);
            d_data_ok   = (bus_pend > 0) && ($urandom_range(99) < 50);
            d_rdata     = {$urandom, $urandom};
            d_out_ready = ($urandom_range(99) < 70);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
